// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg: shared FSM states, read-during-write constants and latency check for sync_ram_be
`ifndef SYNC_RAM_PKG_SV
`define SYNC_RAM_PKG_SV
`define SYNC_RAM_LAT_OK(l) ((l) == 1 || (l) == 2)
package sync_ram_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
endpackage
`endif

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset clear sequencer; walks every address writing zero, then raises ready
// Ports: clk, rst_n (async active-low) in; ready, clr_en, clr_addr out
module ram_clear_seq
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  always_comb state_nx = (state == ST_CLEAR && &cnt) ? ST_IDLE : state;
  assign clr_en   = state == ST_CLEAR;
  assign clr_addr = cnt;
  // ready lags the state by one edge, so it rises on the edge after the last clear write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_RST;
      cnt   <= '0;
      ready <= CLEAR_ON_RESET == 0;
    end else begin
      state <= state_nx;
      cnt   <= clr_en ? cnt + 1'b1 : cnt;
      ready <= state == ST_IDLE;
    end
endmodule

// File: rtl/sync_ram_be.sv
// sync_ram_be: single-port synchronous RAM with byte enables, 1/2-cycle read latency, RDW mode and post-reset clear
// Ports: clk, rst_n (async active-low), addr, Din, writeEn, byteEn, read in; Dout, DoutValid, ready out
module sync_ram_be
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   Din,
  input  logic                    writeEn,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   Dout,
  output logic                    DoutValid,
  output logic                    ready
);
  localparam int NB = DATA_WIDTH / 8;
  if (!`SYNC_RAM_LAT_OK(READ_LATENCY) || DATA_WIDTH % 8 != 0) begin : g_bad_param
    $error("sync_ram_be: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  clr_en, wr, rd, wr_en;
  logic [ADDR_WIDTH-1:0] clr_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, merged, rd_word, d1;
  logic [NB-1:0]         wr_be;
  logic                  v1;
  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );
  assign wr      = ready & writeEn;
  assign rd      = ready & read;
  // clear sequencer owns the write port until it finishes
  assign wr_en   = clr_en | wr;
  assign wr_addr = clr_en ? clr_addr : addr;
  assign wr_data = clr_en ? '0 : Din;
  assign wr_be   = clr_en ? '1 : byteEn;
  always_ff @(posedge clk)
    if (wr_en)
      for (int k = 0; k < NB; k++)
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
  always_comb begin
    merged = mem[addr];
    for (int k = 0; k < NB; k++)
      merged[8*k +: 8] = byteEn[k] ? Din[8*k +: 8] : mem[addr][8*k +: 8];
  end
  assign rd_word = (RDW_MODE == RDW_NEW && writeEn) ? merged : mem[addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd;
      if (rd) d1 <= rd_word;
    end
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    assign Dout      = d2;
    assign DoutValid = v2;
  end else begin : g_lat1
    assign Dout      = d1;
    assign DoutValid = v1;
  end
endmodule

// File: tb/tb_sync_ram_be.sv
// tb_sync_ram_be: directed bench driving a latency-1/old-data RAM and a latency-2/new-data RAM in lockstep
module tb_sync_ram_be;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  addr = '0;
  logic [31:0] Din = '0;
  logic        writeEn = 0, read = 0;
  logic [3:0]  byteEn = '0;
  logic [31:0] dout_a, dout_b;
  logic        valid_a, valid_b, ready_a, ready_b;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sync_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .Din(Din), .writeEn(writeEn), .byteEn(byteEn),
    .read(read), .Dout(dout_a), .DoutValid(valid_a), .ready(ready_a));
  sync_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .Din(Din), .writeEn(writeEn), .byteEn(byteEn),
    .read(read), .Dout(dout_b), .DoutValid(valid_b), .ready(ready_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout_a"}, dout_a, 0);
    chk({tag, "_dout_b"}, dout_b, 0);
    chk({tag, "_vld_a"}, {31'b0, valid_a}, 0);
    chk({tag, "_vld_b"}, {31'b0, valid_b}, 0);
    chk({tag, "_rdy_a"}, {31'b0, ready_a}, 0);
    chk({tag, "_rdy_b"}, {31'b0, ready_b}, 0);
  endtask

  // Counts the 16 clear edges, trying a write to addr 2 that must be ignored
  task automatic wait_clear();
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      writeEn = (i == 5);
      addr    = 4'd2;
      Din     = 32'hDEAD_BEEF;
      byteEn  = 4'hF;
      chk($sformatf("clr_rdy_a%0d", i), {31'b0, ready_a}, 0);
      chk($sformatf("clr_rdy_b%0d", i), {31'b0, ready_b}, 0);
    end
    @(posedge clk); #1;
    chk("rdy_up_a", {31'b0, ready_a}, 1);
    chk("rdy_up_b", {31'b0, ready_b}, 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; Din = d; byteEn = be; writeEn = 1;
    @(posedge clk); #1;
    writeEn = 0;
  endtask

  task automatic access(input logic [3:0] a, input logic we, input logic [31:0] d,
                        input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk);
    addr = a; Din = d; byteEn = 4'hF; writeEn = we; read = 1;
    @(posedge clk); #1;
    read = 0; writeEn = 0;
    chk($sformatf("rd%0d_vld_a", a), {31'b0, valid_a}, 1);
    chk($sformatf("rd%0d_dout_a", a), dout_a, ea);
    chk($sformatf("rd%0d_early_b", a), {31'b0, valid_b}, 0);
    @(posedge clk); #1;
    chk($sformatf("rd%0d_vld_b", a), {31'b0, valid_b}, 1);
    chk($sformatf("rd%0d_dout_b", a), dout_b, eb);
    chk($sformatf("rd%0d_once_a", a), {31'b0, valid_a}, 0);
    @(posedge clk); #1;
    chk($sformatf("rd%0d_once_b", a), {31'b0, valid_b}, 0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    access(a, 0, 32'h0, e, e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst_n = 1;
    wait_clear();
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);
    for (int i = 0; i < 16; i++) wr(4'(i), 32'(2 * i + 1), 4'hF);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'(2 * i + 1));
    wr(4'd3, 32'hAABB_CCDD, 4'hF);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd(4'd3, 32'hAA22_CC44);
    wr(4'd5, 32'h0000_0007, 4'hF);
    access(4'd5, 1, 32'h0000_0009, 32'h0000_0007, 32'h0000_0009);
    rd(4'd5, 32'h0000_0009);
    wr(4'd3, 32'h0000_0007, 4'hF);
    @(negedge clk) addr = 4'd1; read = 1;
    @(posedge clk); #1;
    chk("b2b1_vld_a", {31'b0, valid_a}, 1); chk("b2b1_dout_a", dout_a, 3);
    chk("b2b1_vld_b", {31'b0, valid_b}, 0);
    @(negedge clk) addr = 4'd2;
    @(posedge clk); #1;
    chk("b2b2_vld_a", {31'b0, valid_a}, 1); chk("b2b2_dout_a", dout_a, 5);
    chk("b2b2_vld_b", {31'b0, valid_b}, 1); chk("b2b2_dout_b", dout_b, 3);
    @(negedge clk) addr = 4'd3;
    @(posedge clk); #1;
    read = 0;
    chk("b2b3_vld_a", {31'b0, valid_a}, 1); chk("b2b3_dout_a", dout_a, 7);
    chk("b2b3_vld_b", {31'b0, valid_b}, 1); chk("b2b3_dout_b", dout_b, 5);
    @(posedge clk); #1;
    chk("b2b4_vld_a", {31'b0, valid_a}, 0);
    chk("b2b4_vld_b", {31'b0, valid_b}, 1); chk("b2b4_dout_b", dout_b, 7);
    @(posedge clk); #1;
    chk("b2b5_vld_b", {31'b0, valid_b}, 0);
    @(negedge clk) addr = 4'd4; read = 1;
    @(posedge clk); #1;
    read = 0;
    chk("midrd_vld_a", {31'b0, valid_a}, 1); chk("midrd_dout_a", dout_a, 9);
    #2 rst_n = 0;
    #1 chk_reset("rst_midrd");
    @(negedge clk) rst_n = 1;
    repeat (8) @(posedge clk);
    #1 chk("midclr_rdy_a", {31'b0, ready_a}, 0);
    #2 rst_n = 0;
    #1 chk_reset("rst_midclr");
    @(negedge clk) rst_n = 1;
    wait_clear();
    rd(4'd2, 32'h0);
    rd(4'd4, 32'h0);
    rd(4'd15, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_ram_be.md
# sync_ram_be

Parametrised successor to the single-port `sync_ram`. It is a single-port synchronous RAM with:
- configurable data width and depth;
- per-byte write enables;
- selectable read latency (1 or 2 cycles) and read-during-write mode;
- a read-valid strobe;
- a post-reset clear sequencer that zeroes the array before it accepts traffic.

It sits wherever `sync_ram` sits today (processor data memory, scratch buffers). The `ready`/`DoutValid` handshake lets it be used unchanged behind pipelined requesters.

## Interface
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, default 16: address bits; depth = 2^ADDR_WIDTH words.
- `READ_LATENCY`, default 1: 1 = array output register only; 2 = additional output register. No other values are legal.
- `RDW_MODE`, default 0: read-during-write to the same address. 0 = read returns old data; 1 = read returns newly written (byte-merged) data.
- `CLEAR_ON_RESET`, default 1: 1 = zero every word after reset release; 0 = contents undefined, ready immediately.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `addr`, input, ADDR_WIDTH: word address.
- `Din`, input, DATA_WIDTH: write data.
- `writeEn`, input, 1: write request.
- `byteEn`, input, DATA_WIDTH/8: byte lanes written when `writeEn`=1; bit k covers `Din[8k+7:8k]`.
- `read`, input, 1: read request.
- `Dout`, output, DATA_WIDTH: read data; holds its last value between reads.
- `DoutValid`, output, 1: one-cycle strobe marking new `Dout`.
- `ready`, output, 1: requests are accepted only while high.

## Operation
- **FSM states:** CLEAR and IDLE.
  - Reset entry: CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - CLEAR: a clear counter walks addresses 0 to 2^ADDR_WIDTH-1, writing 0 to one word per cycle. After the last address it moves to IDLE.
  - IDLE persists until reset.
- **`ready`:** equals (state == IDLE), registered.
- **Request acceptance:** a request is accepted on a rising edge where `ready`=1 and (`writeEn` | `read`). Requests while `ready`=0 are ignored completely: no write, no `DoutValid`.
- **Write:** each lane with `byteEn`[k]=1 takes `Din` bits for that lane; all other lanes keep their stored value. `writeEn`=1 with `byteEn`=0 is a legal no-op write.
- **Read:** returns the word at `addr` after READ_LATENCY cycles.
- **Simultaneous `writeEn` and `read`:** same address by construction (single port). The write is performed. The read result follows RDW_MODE; in mode 1 the result is the lane-merged word.
- **Reads are pipelined:** back-to-back reads, one per cycle, produce `DoutValid` high on consecutive cycles in request order.
- **Address width:** `addr` is used as-is; no wrap logic is needed because the width exactly covers the depth.

## Timing
- **Reset values:**
  - `Dout` = 0, `DoutValid` = 0, both pipeline stages cleared.
  - `ready` = 0 if CLEAR_ON_RESET=1, else 1.
  - Clear counter = 0.
- **Clear duration:** exactly 2^ADDR_WIDTH cycles after the first rising edge following `rst_n` release. `ready` rises on the next edge.
- **Read latency:** request at edge N gives `Dout`/`DoutValid` updated at edge N+READ_LATENCY, so they are visible in cycle N+READ_LATENCY.
- **Write timing:** a write at edge N is visible to a read accepted at edge N+1 in either RDW_MODE.
- **Reset mid-operation:**
  - Asserting `rst_n` low immediately clears `Dout`, `DoutValid`, the pipeline and `ready`; in-flight reads are dropped.
  - A reset during CLEAR restarts clearing from address 0.
  - Array contents are not reset except by the clear sequence.
- **`DoutValid`:** never high for more than one cycle per accepted read.

## Structure
- **Shared package/header `sync_ram_pkg`:**
  - FSM state encodings (`ST_CLEAR`, `ST_IDLE`);
  - RDW mode constants (`RDW_OLD`=0, `RDW_NEW`=1);
  - latency legality check macro.
- **Sub-module `ram_clear_seq`:** holds the FSM, clear counter, `ready`, and the clear write address/enable.
- The top level muxes the clear write path over the user write path.

## Test plan
- **Clear after reset:** ADDR_WIDTH=4, CLEAR_ON_RESET=1. Release reset, then:
  - `ready` stays low for 16 cycles, then goes high;
  - reading addresses 0 to 15 returns 0.
- **Fill and readback:** write 2i+1 to index i for all 16 addresses, `byteEn`=4'hF. Read back each address:
  - `Dout` = 2i+1, `DoutValid` high READ_LATENCY cycles after each read;
  - repeat with READ_LATENCY=2.
- **Byte lanes:** write 32'hAABBCCDD to addr 3 with `byteEn`=4'hF, then 32'h11223344 with `byteEn`=4'b0101. Reading addr 3 returns 32'hAA22CC44.
- **Read-during-write:** addr 5 holds 32'h0000_0007. Issue write 32'h0000_0009 and read in the same cycle:
  - RDW_MODE=0 returns 7;
  - RDW_MODE=1 returns 9;
  - a subsequent read returns 9 in both modes.
- **Back-to-back reads:** read addresses 1, 2, 3 on consecutive cycles. `DoutValid` is high for 3 consecutive cycles with `Dout` = 3, 5, 7.
- **Ignored requests and reset:**
  - A write issued while `ready`=0 is lost (later read returns 0).
  - Asserting `rst_n` low mid-clear or mid-read forces `Dout`=0, `DoutValid`=0, `ready`=0 immediately.
  - After that reset, clearing restarts from address 0.
